countdown_sequencer: RTL and testbench
======================================

# countdown_sequencer

Loadable down-counter that sequences a fixed number of iteration steps for the shift-add multiplier datapath: it accepts a step count via a valid/ready handshake, asserts `step` once per active cycle, and pulses `done` after the last step. It is the decrementing, job-driven counterpart of the free-running up counter. It adds pause, abort and an auto-reload mode for back-to-back multiply operations.

## Interface
- `WIDTH`, 8: width of the count, load value and reload tally.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `load_valid` in 1: `load_value` and `reload_en` are valid.
- `load_ready` out 1: the block accepts a load; high only in IDLE.
- `load_value` in WIDTH: number of steps to issue; 0 is legal.
- `reload_en` in 1: latched on an accepted load; selects auto-reload mode.
- `pause` in 1: freezes stepping while high.
- `abort` in 1: terminates the job immediately, with no `done`.
- `count` out WIDTH: remaining steps, registered.
- `busy` out 1: high while state is not IDLE.
- `step` out 1: combinational; one iteration is performed this cycle.
- `done` out 1: registered one-cycle pulse after the final step of a period.
- `reloads` out WIDTH: number of completed periods in reload mode, saturating.

## Operation
- States:
  - IDLE: waiting for a load.
  - RUN: issuing steps.
  - PAUSE: holding the current count.
- Reset (reset=0): state IDLE; `count`, `done`, `reloads`, stored period and reload flag all 0.
- `load_ready` = (state==IDLE). `busy` = (state!=IDLE).
- `step` = (state==RUN) && !pause && !abort.
- IDLE, load accepted (`load_valid` && `load_ready`):
  - Store the period (`load_value`) and the `reload_en` flag.
  - Clear `reloads`.
  - If `load_value` != 0: `count` <= `load_value`, go to RUN.
  - If `load_value` == 0: stay IDLE; `done` <= 1 on the next cycle; no `step` is issued.
- RUN, in priority order:
  1. `abort`: go to IDLE; `count` <= 0; no `done`.
  2. `pause`: go to PAUSE; `count` held.
  3. Otherwise `step`=1, then:
     - If `count` > 1: `count` <= `count` − 1.
     - If `count` == 1 (final step): `done` <= 1.
       - Reload flag set: `count` <= stored period; stay RUN; `reloads` <= `reloads` + 1, saturating at 2^WIDTH−1.
       - Reload flag clear: `count` <= 0; go to IDLE.
- PAUSE:
  - `abort`: go to IDLE; `count` <= 0.
  - `pause` low: go to RUN; stepping resumes the next cycle.
  - Otherwise hold.
- `done` is 0 in every cycle not covered above.
- `load_valid` outside IDLE is ignored; there is no buffering.
- Reload mode ends only via `abort`.
- Arithmetic is unsigned with no wrap below 0; `count` never underflows.

## Timing
- Load accepted at edge k with value N ≥ 1, and no pause:
  - `step` high in cycles k+1 through k+N.
  - `done` high in cycle k+N+1.
  - `load_ready` high again in cycle k+N+1, so the next load can be accepted in the same cycle as `done`.
- Minimum job-to-job gap: 1 idle cycle.
- Reload mode: `step` is continuous; `done` pulses every N cycles with no gap cycle.
- Zero-length load at edge k: `done` high in cycle k+1; `busy` stays 0.
- Pause: `step` drops in the same cycle `pause` is high (combinational). A pause of P cycles extends the job by exactly P cycles plus 1 resume cycle.
- Abort and pause in the same cycle: abort wins.
- Abort during the final step: no `done`; `reloads` is unchanged.
- Reset asserted mid-job: all outputs return to their reset values immediately and asynchronously. The first load is accepted on the first edge after release.

## Structure
- Shared package `countdown_pkg` holds the state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2) and the default `WIDTH`.
- One sub-module, `sat_counter`: a parameterised saturating up counter with synchronous clear, used for `reloads`.
- The FSM and down-count remain in the top module.

## Test plan
- Load N=5 with `reload_en`=0 → `step` high for 5 cycles, `count` goes 5,4,3,2,1; `done` pulses the cycle after; `busy` falls; `reloads`=0.
- Load N=0 → no `step`; `done` pulses in the next cycle; `busy` never asserts; `load_ready` stays 1.
- Load N=3 with `reload_en`=1 and run 10 steps → `done` at steps 3, 6, 9; `reloads` = 3; abort during step 10 → IDLE, `count`=0, no `done`.
- Load N=4; assert `pause` for 3 cycles after the 2nd step → `count` held at 2; exactly 4 steps in total; `done` arrives 4 cycles later than the unpaused case.
- Assert `abort` and `pause` together during the final step (`count`=1) → IDLE, no `done`; a new load in the following cycle is accepted. With `load_valid` held high during RUN, the held load is not accepted until IDLE.
- Drive reset low mid-job with `count`=7 → `count`, `busy`, `done` go to 0 without waiting for a clock edge. WIDTH=4 in reload mode with N=1 for 20 cycles → `reloads` saturates at 15.

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown sequencer: FSM state encodings and default width.
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != {WIDTH{1'b1}})) begin
      value_d = value_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/countdown_sequencer.sv
// Loadable down-counter issuing one step per active cycle, with pause, abort and auto-reload.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             reload_en,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             step,
  output logic             done,
  output logic [WIDTH-1:0] reloads
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             reload_q, reload_d;
  logic             done_q, done_d;
  logic             reloads_clr;
  logic             reloads_inc;
  logic             load_fire;

  assign load_fire = load_valid && (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_fire && (load_value != '0)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                                  state_d = ST_IDLE;
        else if (pause)                             state_d = ST_PAUSE;
        else if ((count_q <= ONE) && !reload_q)     state_d = ST_IDLE;
      end
      ST_PAUSE: begin
        if (abort)       state_d = ST_IDLE;
        else if (!pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A zero-length load finishes immediately: done without ever leaving IDLE.
  always_comb begin
    count_d     = count_q;
    period_d    = period_q;
    reload_d    = reload_q;
    done_d      = 1'b0;
    reloads_clr = 1'b0;
    reloads_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          period_d    = load_value;
          reload_d    = reload_en;
          reloads_clr = 1'b1;
          if (load_value != '0) count_d = load_value;
          else                  done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          count_d = '0;
        end else if (!pause) begin
          if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else begin
            done_d = 1'b1;
            if (reload_q) begin
              count_d     = period_q;
              reloads_inc = 1'b1;
            end else begin
              count_d = '0;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (abort) count_d = '0;
      end
      default: count_d = '0;
    endcase
  end

  always_comb begin
    load_ready = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    step       = (state_q == ST_RUN) && !pause && !abort;
  end

  sat_counter #(
    .WIDTH(WIDTH)
  ) u_reloads (
    .clk  (clk),
    .reset(reset),
    .clear(reloads_clr),
    .inc  (reloads_inc),
    .value(reloads)
  );

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed self-checking bench for countdown_sequencer (WIDTH=8 plus a WIDTH=4 saturation instance).
module tb_countdown_sequencer;

  logic       clk;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       reload_en;
  logic       pause;
  logic       abort;
  logic [7:0] count;
  logic       busy;
  logic       step;
  logic       done;
  logic [7:0] reloads;

  logic       load_valid4;
  logic       load_ready4;
  logic [3:0] load_value4;
  logic       reload_en4;
  logic       pause4;
  logic       abort4;
  logic [3:0] count4;
  logic       busy4;
  logic       step4;
  logic       done4;
  logic [3:0] reloads4;

  int checks = 0;
  int errors = 0;
  int stepTally;

  int pauseStepExp  [8] = '{1, 1, 0, 0, 0, 0, 1, 1};
  int pauseCountExp [8] = '{4, 3, 2, 2, 2, 2, 2, 1};

  countdown_sequencer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_value(load_value),
    .reload_en (reload_en),
    .pause     (pause),
    .abort     (abort),
    .count     (count),
    .busy      (busy),
    .step      (step),
    .done      (done),
    .reloads   (reloads)
  );

  countdown_sequencer #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid4),
    .load_ready(load_ready4),
    .load_value(load_value4),
    .reload_en (reload_en4),
    .pause     (pause4),
    .abort     (abort4),
    .count     (count4),
    .busy      (busy4),
    .step      (step4),
    .done      (done4),
    .reloads   (reloads4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [7:0] lval, input logic ren,
                               input logic p, input logic a);
    load_valid = lv;
    load_value = lval;
    reload_en  = ren;
    pause      = p;
    abort      = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    reset       = 1'b0;
    load_valid4 = 1'b0;
    load_value4 = '0;
    reload_en4  = 1'b0;
    pause4      = 1'b0;
    abort4      = 1'b0;
    applyStimulus(0, 8'd0, 0, 0, 0);
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_reloads", reloads, 0);
    checkOutput("rst_ready", load_ready, 1);
    #11 reset = 1'b1;
    tick();

    $display("[TB] single job N=5");
    applyStimulus(1, 8'd5, 0, 0, 0);
    #1 checkOutput("n5_idle_step", step, 0);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("n5_step", step, 1);
      checkOutput("n5_count", count, 5 - i);
      checkOutput("n5_busy", busy, 1);
      checkOutput("n5_nodone", done, 0);
      tick();
    end
    checkOutput("n5_done", done, 1);
    checkOutput("n5_busy_fall", busy, 0);
    checkOutput("n5_ready", load_ready, 1);
    checkOutput("n5_count0", count, 0);
    checkOutput("n5_reloads", reloads, 0);
    checkOutput("n5_poststep", step, 0);
    tick();
    checkOutput("n5_done_pulse", done, 0);

    $display("[TB] zero-length load");
    applyStimulus(1, 8'd0, 0, 0, 0);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    #1;
    checkOutput("n0_done", done, 1);
    checkOutput("n0_busy", busy, 0);
    checkOutput("n0_ready", load_ready, 1);
    checkOutput("n0_step", step, 0);
    tick();
    checkOutput("n0_done_pulse", done, 0);

    $display("[TB] reload mode N=3");
    applyStimulus(1, 8'd3, 1, 0, 0);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    for (int s = 1; s <= 9; s++) begin
      #1;
      checkOutput("rl_step", step, 1);
      checkOutput("rl_count", count, 3 - ((s - 1) % 3));
      checkOutput("rl_done", done, (s > 1 && ((s - 1) % 3) == 0) ? 1 : 0);
      checkOutput("rl_reloads", reloads, (s - 1) / 3);
      tick();
    end
    checkOutput("rl_s10_done", done, 1);
    checkOutput("rl_s10_reloads", reloads, 3);
    checkOutput("rl_s10_count", count, 3);
    applyStimulus(0, 8'd0, 0, 0, 1);
    #1 checkOutput("rl_abort_step", step, 0);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    checkOutput("rl_abort_busy", busy, 0);
    checkOutput("rl_abort_count", count, 0);
    checkOutput("rl_abort_done", done, 0);
    checkOutput("rl_abort_reloads", reloads, 3);

    $display("[TB] pause N=4");
    applyStimulus(1, 8'd4, 0, 0, 0);
    tick();
    stepTally = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(0, 8'd0, 0, (c >= 2 && c <= 4), 0);
      #1;
      checkOutput("ps_step", step, pauseStepExp[c]);
      checkOutput("ps_count", count, pauseCountExp[c]);
      checkOutput("ps_nodone", done, 0);
      if (step) stepTally++;
      tick();
    end
    checkOutput("ps_done", done, 1);
    checkOutput("ps_steps", stepTally, 4);
    checkOutput("ps_busy", busy, 0);

    $display("[TB] abort+pause on final step, held load");
    applyStimulus(1, 8'd2, 0, 0, 0);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    tick();
    checkOutput("ap_count1", count, 1);
    applyStimulus(0, 8'd0, 0, 1, 1);
    #1 checkOutput("ap_step", step, 0);
    tick();
    checkOutput("ap_busy", busy, 0);
    checkOutput("ap_count", count, 0);
    checkOutput("ap_done", done, 0);
    applyStimulus(1, 8'd1, 0, 0, 0);
    tick();
    checkOutput("ap_reload_busy", busy, 1);
    checkOutput("ap_reload_count", count, 1);
    applyStimulus(1, 8'd3, 0, 0, 0);
    #1 checkOutput("hold_ready", load_ready, 0);
    tick();
    checkOutput("hold_done", done, 1);
    checkOutput("hold_count", count, 0);
    checkOutput("hold_ready_idle", load_ready, 1);
    tick();
    checkOutput("hold_accept_busy", busy, 1);
    checkOutput("hold_accept_count", count, 3);
    applyStimulus(0, 8'd0, 0, 0, 1);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    checkOutput("hold_abort_busy", busy, 0);

    $display("[TB] async reset mid-job");
    applyStimulus(1, 8'd9, 0, 0, 0);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    tick();
    tick();
    checkOutput("ar_count7", count, 7);
    #2 reset = 1'b0;
    #1;
    checkOutput("ar_count", count, 0);
    checkOutput("ar_busy", busy, 0);
    checkOutput("ar_done", done, 0);
    checkOutput("ar_ready", load_ready, 1);
    applyStimulus(1, 8'd2, 0, 0, 0);
    #2 reset = 1'b1;
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);
    checkOutput("ar_first_busy", busy, 1);
    checkOutput("ar_first_count", count, 2);
    applyStimulus(0, 8'd0, 0, 0, 1);
    tick();
    applyStimulus(0, 8'd0, 0, 0, 0);

    $display("[TB] WIDTH=4 reload saturation");
    load_valid4 = 1'b1;
    load_value4 = 4'd1;
    reload_en4  = 1'b1;
    tick();
    load_valid4 = 1'b0;
    load_value4 = 4'd0;
    reload_en4  = 1'b0;
    checkOutput("w4_step", step4, 1);
    checkOutput("w4_reloads0", reloads4, 0);
    for (int m = 0; m < 5; m++) tick();
    checkOutput("w4_reloads5", reloads4, 5);
    checkOutput("w4_done", done4, 1);
    for (int m = 0; m < 15; m++) tick();
    checkOutput("w4_reloads_sat", reloads4, 15);
    checkOutput("w4_count", count4, 1);
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    checkOutput("w4_abort_busy", busy4, 0);
    checkOutput("w4_abort_reloads", reloads4, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
